// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment scanner: one shared segment bus driven across NDIGITS digits,
// with frame-synchronous value update and a dark guard at the start of every digit slot.
module sevenseg_scanner #(
  parameter int NDIGITS      = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  output logic [6:0]             segments,
  output logic                   dp,
  output logic [NDIGITS-1:0]     digit_en,
  output logic                   frame_done,
  output logic [1:0]             debug_state
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  state_t              state, state_nxt, slot_first;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                slot_end, last_digit;

  logic [4*NDIGITS-1:0] pend_val, disp_val, pend_src_val, disp_val_nxt;
  logic [NDIGITS-1:0]   pend_dp, disp_dp, pend_src_dp, disp_dp_nxt;
  logic                 boundary;

  logic [6:0]           seg_d;
  logic                 dp_d, fd_d, show;
  logic [NDIGITS-1:0]   de_d;
  logic [3:0]           nib;

  assign debug_state = state;
  assign slot_end    = (cnt == CW'(PRESCALE - 1));
  assign last_digit  = (idx == IW'(NDIGITS - 1));
  assign slot_first  = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h7E;  4'h1: dec = 7'h30;  4'h2: dec = 7'h6D;  4'h3: dec = 7'h79;
      4'h4: dec = 7'h33;  4'h5: dec = 7'h5B;  4'h6: dec = 7'h5F;  4'h7: dec = 7'h70;
      4'h8: dec = 7'h7F;  4'h9: dec = 7'h7B;  4'hA: dec = 7'h77;  4'hB: dec = 7'h1F;
      4'hC: dec = 7'h4E;  4'hD: dec = 7'h3D;  4'hE: dec = 7'h4F;  default: dec = 7'h47;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = slot_first;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK, SHOW: begin
          if (slot_end) begin
            cnt_nxt   = '0;
            idx_nxt   = last_digit ? '0 : idx + IW'(1);
            state_nxt = slot_first;
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1))
              state_nxt = SHOW;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The registered frame_done marks the boundary cycle; the display path reads disp_val_nxt so a
  // value taken over on that cycle (including a same-cycle load) is already used for digit 0.
  assign boundary     = (state == IDLE) || frame_done;
  assign pend_src_val = load ? value : pend_val;
  assign pend_src_dp  = load ? dp_in : pend_dp;
  assign disp_val_nxt = boundary ? pend_src_val : disp_val;
  assign disp_dp_nxt  = boundary ? pend_src_dp : disp_dp;

  always_comb begin
    show  = enable && (state == SHOW);
    nib   = disp_val_nxt[4*idx +: 4];
    seg_d = show ? dec(nib) : 7'h00;
    dp_d  = show && disp_dp_nxt[idx];
    de_d  = show ? (NDIGITS'(1) << idx) : '0;
    fd_d  = enable && (state != IDLE) && slot_end && last_digit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segments   <= '0;
      dp         <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      segments   <= seg_d;
      dp         <= dp_d;
      digit_en   <= de_d;
      frame_done <= fd_d;
      pend_val   <= pend_src_val;
      pend_dp    <= pend_src_dp;
      disp_val   <= disp_val_nxt;
      disp_dp    <= disp_dp_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner: a frame-position model predicts every output cycle,
// expectations flow through a queue and are compared one cycle after the inputs are applied.
module tb_sevenseg_scanner;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
  localparam int W = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [6:0]    segments;
  logic          dp;
  logic [3:0]    digit_en;
  logic          frame_done;
  logic [1:0]    debug_state;

  sevenseg_scanner #(.NDIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .segments(segments), .dp(dp), .digit_en(digit_en), .frame_done(frame_done),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0] dec_tab[16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // model: position within the frame, pending/displayed values, last predicted frame_done
  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_pend = '0, m_disp = '0;
  logic [3:0]  m_pdp = '0, m_ddp = '0;
  bit          m_fd = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {frame_done, dp, digit_en, segments};
  endfunction

  task automatic predict();
    logic [W-1:0] e;
    logic [15:0]  dv;
    logic [3:0]   ddp;
    logic [3:0]   nb;
    int           slot, off;
    e = '0;
    if (!reset_n) begin
      m_active = 1'b0; m_pos = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_fd = 1'b0;
      exp_q.push_back(e);
      return;
    end
    if (!m_active || m_fd) begin
      dv  = load ? value : m_pend;
      ddp = load ? dp_in : m_pdp;
    end else begin
      dv  = m_disp;
      ddp = m_ddp;
    end
    if (m_active && enable) begin
      slot = m_pos / P;
      off  = m_pos % P;
      if (off >= B) begin
        nb = 4'((dv >> (4 * slot)) & 16'hF);
        e[6:0]  = dec_tab[nb];
        e[10:7] = 4'b0001 << slot;
        e[11]   = ddp[slot];
      end
      e[12] = (slot == N - 1) && (off == P - 1);
    end
    exp_q.push_back(e);
    m_disp = dv;
    m_ddp  = ddp;
    if (load) begin
      m_pend = value;
      m_pdp  = dp_in;
    end
    m_fd = e[12];
    if (!enable) begin
      m_active = 1'b0; m_pos = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % (N * P);
    end
  endtask

  task automatic step(input string tag);
    logic [W-1:0] e;
    predict();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val(tag, 32'(observed()), 32'(e));
    check_val({tag, "_onehot"}, 32'($countones(digit_en) <= 1), 32'd1);
  endtask

  initial begin
    logic [15:0] r;
    bit found;

    // reset with enable and load active
    enable = 1'b1; load = 1'b1; value = 16'h1234; dp_in = 4'hF;
    #1 reset_n = 1'b0;
    #1 check_val("reset_async", 32'(observed()), 32'd0);
    repeat (3) step("reset_hold");
    reset_n = 1'b1; enable = 1'b0;

    // basic scan of 3210
    value = 16'h3210; dp_in = 4'b0000; load = 1'b1;
    step("idle_load");
    load = 1'b0; enable = 1'b1;
    repeat (3 * N * P) step("scan_3210");

    // mid-frame load must not tear the current frame
    while (m_pos != 10) step("align");
    value = 16'hFFFF; load = 1'b1;
    step("mid_load");
    load = 1'b0;
    repeat (2 * N * P) step("after_ffff");

    // load coinciding with the frame boundary takes the bypass
    found = 1'b0;
    for (int i = 0; i < 2 * N * P && !found; i++) begin
      if (frame_done) found = 1'b1;
      else step("wait_fd");
    end
    check_val("fd_seen", 32'(found), 32'd1);
    value = 16'hAAAA; load = 1'b1;
    step("boundary_load");
    load = 1'b0;
    repeat (2 * N * P) step("after_aaaa");

    // every nibble on digit 0, random other digits and decimal points
    for (int k = 0; k < 16; k++) begin
      r = 16'($urandom_range(0, 16'hFFFF));
      value = {r[15:4], 4'(k)};
      dp_in = 4'($urandom_range(0, 15));
      load = 1'b1;
      step("nib_load");
      load = 1'b0;
      repeat (48) step("nib_show");
    end

    // disable during digit 2, then re-enable
    found = 1'b0;
    for (int i = 0; i < 2 * N * P && !found; i++) begin
      if (digit_en == 4'b0100) found = 1'b1;
      else step("wait_d2");
    end
    check_val("d2_seen", 32'(found), 32'd1);
    enable = 1'b0;
    step("disable");
    check_val("disable_dark", 32'(observed()), 32'd0);
    repeat (5) step("parked");
    enable = 1'b1;
    repeat (2 * N * P) step("reenable");

    // reset mid-frame loses the pending load
    while (m_pos != 20) step("align2");
    value = 16'h5555; load = 1'b1;
    step("pre_reset_load");
    load = 1'b0;
    reset_n = 1'b0;
    #1 check_val("reset_mid", 32'(observed()), 32'd0);
    repeat (2) step("reset_mid_hold");
    reset_n = 1'b1;
    repeat (2 * N * P + 4) step("post_reset");

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
